// File: rtl/lsu_dtag_perr_ctl.sv
// rtl/lsu_dtag_perr_ctl.sv - L1D tag parity error recovery sequencer
// Flushes the errored load, invalidates every way of its set, and logs the event.
module lsu_dtag_perr_ctl #(
    parameter int IDX_W = 7,
    parameter int WAYS  = 4,
    parameter int CNT_W = 8
) (
    input  logic             rclk,
    input  logic             rst_l,
    input  logic [WAYS-1:0]  lsu_rd_dtag_parity_g,
    input  logic             ld_inst_vld_g,
    input  logic [IDX_W-1:0] ld_set_idx_g,
    input  logic             perr_en,
    input  logic             dva_wr_gnt,
    input  logic             log_clr,
    output logic             perr_flush_w2,
    output logic             dva_wr_req,
    output logic [IDX_W-1:0] dva_wr_idx,
    output logic [WAYS-1:0]  dva_wr_way_en,
    output logic             perr_busy,
    output logic             perr_log_vld,
    output logic [IDX_W-1:0] perr_log_idx,
    output logic [WAYS-1:0]  perr_log_way,
    output logic             perr_log_multi,
    output logic [CNT_W-1:0] perr_err_cnt
);
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, INV, DONE} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] way_ptr, way_ptr_nxt;
    logic [IDX_W-1:0] idx_q;
    logic [WAYS-1:0]  way_q;
    logic             flush_q;
    logic             detect;
    logic             capture;
    logic             last_way;

    assign detect   = ld_inst_vld_g & perr_en & (|lsu_rd_dtag_parity_g);
    assign last_way = (way_ptr == PTR_W'(WAYS - 1));

    always_comb begin
        state_nxt   = state;
        way_ptr_nxt = way_ptr;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (detect) begin
                    state_nxt   = INV;
                    way_ptr_nxt = '0;
                    capture     = 1'b1;
                end
            end
            INV: begin
                if (dva_wr_gnt) begin
                    if (last_way) state_nxt = DONE;
                    else          way_ptr_nxt = way_ptr + PTR_W'(1);
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                way_ptr_nxt = '0;
            end
            default: begin
                state_nxt   = IDLE;
                way_ptr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= IDLE;
            way_ptr <= '0;
            flush_q <= 1'b0;
            idx_q   <= '0;
            way_q   <= '0;
        end else begin
            state   <= state_nxt;
            way_ptr <= way_ptr_nxt;
            flush_q <= capture;
            if (capture) begin
                idx_q <= ld_set_idx_g;
                way_q <= lsu_rd_dtag_parity_g;
            end
        end
    end

    // Outputs decode only registered state, never the live inputs.
    assign perr_flush_w2 = flush_q;
    assign perr_busy     = (state != IDLE);
    assign dva_wr_req    = (state == INV);
    assign dva_wr_idx    = dva_wr_req ? idx_q : '0;
    assign dva_wr_way_en = dva_wr_req ? ({{(WAYS-1){1'b0}}, 1'b1} << way_ptr) : '0;

    // A clear coinciding with DONE is applied first, so the new event becomes the first log entry.
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            perr_log_vld   <= 1'b0;
            perr_log_idx   <= '0;
            perr_log_way   <= '0;
            perr_log_multi <= 1'b0;
            perr_err_cnt   <= '0;
        end else if (state == DONE) begin
            if (log_clr || !perr_log_vld) begin
                perr_log_vld   <= 1'b1;
                perr_log_idx   <= idx_q;
                perr_log_way   <= way_q;
                perr_log_multi <= 1'b0;
            end else begin
                perr_log_multi <= 1'b1;
            end
            if (log_clr)
                perr_err_cnt <= CNT_W'(1);
            else if (perr_err_cnt != {CNT_W{1'b1}})
                perr_err_cnt <= perr_err_cnt + CNT_W'(1);
        end else if (log_clr) begin
            perr_log_vld   <= 1'b0;
            perr_log_idx   <= '0;
            perr_log_way   <= '0;
            perr_log_multi <= 1'b0;
            perr_err_cnt   <= '0;
        end
    end
endmodule
